// File: rtl/line_window_buffer.sv
// ------------------------------------------------------------------
// line_window_buffer: four rotating line buffers feeding 3x3 windows
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module line_window_buffer #(
  parameter int IMG_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_pixel_data,
  input  logic        in_pixel_valid,
  output logic [71:0] out_pixels_data,
  output logic        out_pixels_valid,
  output logic        out_line_done
);

  localparam int             CW         = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0]  C_LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0]  C_LAST_WIN = CW'(IMG_WIDTH - 3);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [7:0]    line_mem [4][IMG_WIDTH];

  logic [1:0]    wr_buf;
  logic [CW-1:0] wr_col;
  logic [1:0]    rd_base;
  logic [1:0]    rd_base_next;
  logic [CW-1:0] rd_col;
  logic [CW-1:0] rd_col_next;
  logic [2:0]    lines_filled;
  logic          line_complete;
  logic          retire;
  logic          load;
  logic          done_next;
  logic [71:0]   window;

  assign line_complete = in_pixel_valid && (wr_col == C_LAST_COL);

  always_ff @(posedge clk) begin
    if (rst_n && in_pixel_valid) begin
      line_mem[wr_buf][wr_col] <= in_pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_buf <= '0;
      wr_col <= '0;
    end else if (in_pixel_valid) begin
      if (wr_col == C_LAST_COL) begin
        wr_col <= '0;
        wr_buf <= wr_buf + 2'd1;
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  // A line completing and a line retiring on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lines_filled <= '0;
    end else begin
      case ({line_complete, retire})
        2'b10:   lines_filled <= lines_filled + 3'd1;
        2'b01:   lines_filled <= lines_filled - 3'd1;
        default: lines_filled <= lines_filled;
      endcase
    end
  end

  // Window rows come from the three oldest buffers, columns from rd_col..rd_col+2.
  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [1:0] buf_sel;
    assign buf_sel = rd_base + 2'(r);
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [CW-1:0] addr;
      assign addr = rd_col + CW'(c);
      assign window[(r*3 + c)*8 +: 8] = line_mem[buf_sel][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_col_next  = rd_col;
    rd_base_next = rd_base;
    retire       = 1'b0;
    load         = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (lines_filled >= 3'd3) begin
          state_next  = READ;
          rd_col_next = '0;
        end
      end
      READ: begin
        load = 1'b1;
        if (rd_col == C_LAST_WIN) begin
          rd_base_next = rd_base + 2'd1;
          rd_col_next  = '0;
          retire       = 1'b1;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          rd_col_next = rd_col + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_base          <= '0;
      rd_col           <= '0;
      out_pixels_data  <= '0;
      out_pixels_valid <= 1'b0;
      out_line_done    <= 1'b0;
    end else begin
      rd_base          <= rd_base_next;
      rd_col           <= rd_col_next;
      out_pixels_valid <= load;
      out_line_done    <= done_next;
      if (load) begin
        out_pixels_data <= window;
      end
    end
  end

endmodule

`default_nettype wire
